// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel prescaler, row/col counters, sync/blank with pipeline delay.
// Optional VGA_FRAME_COUNT_EN adds a 16-bit frame counter output (frame_cnt).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int OUT_DLY  = 0,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 10
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             en,
  output logic             HS,
  output logic             VS,
  output logic             blank,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             pix_stb,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_FRAME_COUNT_EN
  , output logic [15:0]    frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DLY_N   = (OUT_DLY > 0) ? OUT_DLY : 1;

  localparam logic [COL_W-1:0] H_LAST  = COL_W'(H_TOTAL - 1);
  localparam logic [ROW_W-1:0] V_LAST  = ROW_W'(V_TOTAL - 1);
  localparam logic [2:0]       PS_LAST = 3'(CLK_DIV - 1);
  localparam logic             HS_ON   = 1'(HS_POL);
  localparam logic             VS_ON   = 1'(VS_POL);
  localparam logic [2:0]       IDLE    = {~HS_ON, ~VS_ON, 1'b0};

  if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be 1..8");
  end
  if (OUT_DLY < 0 || OUT_DLY > 4) begin : g_bad_dly
    $error("vga_timing_gen: OUT_DLY must be 0..4");
  end
  if ((H_TOTAL - 1) >= (1 << COL_W)) begin : g_bad_colw
    $error("vga_timing_gen: COL_W too small for H_TOTAL");
  end
  if ((V_TOTAL - 1) >= (1 << ROW_W)) begin : g_bad_roww
    $error("vga_timing_gen: ROW_W too small for V_TOTAL");
  end

  logic [2:0]       presc;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic [2:0]       raw_nxt;
  logic [2:0]       dly [DLY_N];
  logic [2:0]       dly_out;

  // Sync/blank are derived from the counter values about to be loaded so that,
  // with no extra delay, HS/VS/blank line up exactly with the displayed row/col.
  always_comb begin
    tick    = en && (presc == PS_LAST);
    h_wrap  = (col == H_LAST);
    v_wrap  = (row == V_LAST);
    col_nxt = h_wrap ? '0 : col + 1'b1;
    row_nxt = row;
    if (h_wrap) begin
      row_nxt = v_wrap ? '0 : row + 1'b1;
    end
    raw_nxt[2] = ((32'(col_nxt) >= H_ACTIVE + H_FP) &&
                  (32'(col_nxt) <  H_ACTIVE + H_FP + H_SYNC)) ? HS_ON : ~HS_ON;
    raw_nxt[1] = ((32'(row_nxt) >= V_ACTIVE + V_FP) &&
                  (32'(row_nxt) <  V_ACTIVE + V_FP + V_SYNC)) ? VS_ON : ~VS_ON;
    raw_nxt[0] = (32'(col_nxt) >= H_ACTIVE) || (32'(row_nxt) >= V_ACTIVE);
    dly_out    = (OUT_DLY == 0) ? raw_nxt : dly[DLY_N-1];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc       <= '0;
      col         <= '0;
      row         <= '0;
      pix_stb     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      {HS, VS, blank} <= IDLE;
      for (int i = 0; i < DLY_N; i++) begin
        dly[i] <= IDLE;
      end
`ifdef VGA_FRAME_COUNT_EN
      frame_cnt <= '0;
`endif
    end else begin
      pix_stb     <= tick;
      line_start  <= tick && h_wrap;
      frame_start <= tick && h_wrap && v_wrap;
      if (en) begin
        presc <= (presc == PS_LAST) ? '0 : presc + 1'b1;
      end
      // Everything downstream of the prescaler moves one pixel per strobe.
      if (tick) begin
        col <= col_nxt;
        row <= row_nxt;
        dly[0] <= raw_nxt;
        for (int i = 1; i < DLY_N; i++) begin
          dly[i] <= dly[i-1];
        end
        {HS, VS, blank} <= dly_out;
`ifdef VGA_FRAME_COUNT_EN
        if (h_wrap && v_wrap) begin
          frame_cnt <= frame_cnt + 16'd1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small configurations driven by random en/reset,
// checked every cycle against a pixel-index arithmetic model.
module tb_vga_timing_gen;

  localparam int A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 2;
  localparam int A_VA = 4, A_VF = 1, A_VS = 2, A_VB = 1;
  localparam int A_DIV = 2, A_DLY = 0;
  localparam bit A_HP = 1'b0, A_VP = 1'b0;
  localparam int A_FRAME = (A_HA + A_HF + A_HS + A_HB) * (A_VA + A_VF + A_VS + A_VB);

  localparam int B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
  localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int B_DIV = 1, B_DLY = 2;
  localparam bit B_HP = 1'b1, B_VP = 1'b1;
  localparam int B_FRAME = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);

  typedef struct {
    int col; int row;
    bit hs; bit vs; bit blank;
    bit stb; bit ls; bit fs;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic checking = 1'b0;

  logic hs_a, vs_a, blank_a, stb_a, ls_a, fs_a;
  logic [2:0] row_a;
  logic [3:0] col_a;
  logic hs_b, vs_b, blank_b, stb_b, ls_b, fs_b;
  logic [2:0] row_b;
  logic [3:0] col_b;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fcnt_a, fcnt_b;
`endif

  int n_compared = 0;
  int n_mismatched = 0;

  longint n_en = 0;
  bit stepped = 1'b0;
  int fc_a = 0;
  int fc_b = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .CLK_DIV(A_DIV), .HS_POL(0), .VS_POL(0), .OUT_DLY(A_DLY),
    .COL_W(4), .ROW_W(3)
  ) dut_a (
    .CLOCK_50(clk), .reset(reset), .en(en),
    .HS(hs_a), .VS(vs_a), .blank(blank_a), .row(row_a), .col(col_a),
    .pix_stb(stb_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(fcnt_a)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .CLK_DIV(B_DIV), .HS_POL(1), .VS_POL(1), .OUT_DLY(B_DLY),
    .COL_W(4), .ROW_W(3)
  ) dut_b (
    .CLOCK_50(clk), .reset(reset), .en(en),
    .HS(hs_b), .VS(vs_b), .blank(blank_b), .row(row_b), .col(col_b),
    .pix_stb(stb_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(fcnt_b)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input int cycles);
    reset = r;
    en = e;
    repeat (cycles) @(negedge clk);
  endtask

  // The model only counts enabled cycles; everything else is derived from the
  // pixel index that count implies.
  function automatic exp_t modelOut(longint n, bit stp, int div, int dly,
                                    int ha, int hf, int hsy, int hb,
                                    int va, int vf, int vsy, int vb, bit hp, bit vp);
    exp_t e;
    int ht, vt;
    longint k, kd, c, r;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    k = n / div;
    e.col = int'(k % ht);
    e.row = int'((k / ht) % vt);
    kd = (k > dly) ? k - dly : 0;
    c = kd % ht;
    r = (kd / ht) % vt;
    e.hs = (c >= ha + hf && c < ha + hf + hsy) ? hp : !hp;
    e.vs = (r >= va + vf && r < va + vf + vsy) ? vp : !vp;
    e.blank = (c >= ha) || (r >= va);
    e.stb = stp && (n % div == 0);
    e.ls = e.stb && (e.col == 0);
    e.fs = e.ls && (e.row == 0);
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      n_en = 0;
      stepped = 1'b0;
      fc_a = 0;
      fc_b = 0;
    end else if (en) begin
      n_en++;
      stepped = 1'b1;
      if (n_en % A_DIV == 0 && (n_en / A_DIV) % A_FRAME == 0) fc_a = (fc_a + 1) % 65536;
      if (n_en % B_DIV == 0 && (n_en / B_DIV) % B_FRAME == 0) fc_b = (fc_b + 1) % 65536;
    end else begin
      stepped = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      exp_t ea, eb;
      ea = modelOut(n_en, stepped, A_DIV, A_DLY, A_HA, A_HF, A_HS, A_HB,
                    A_VA, A_VF, A_VS, A_VB, A_HP, A_VP);
      eb = modelOut(n_en, stepped, B_DIV, B_DLY, B_HA, B_HF, B_HS, B_HB,
                    B_VA, B_VF, B_VS, B_VB, B_HP, B_VP);
      checkOutput("a_col", 32'(col_a), 32'(ea.col));
      checkOutput("a_row", 32'(row_a), 32'(ea.row));
      checkOutput("a_hs", 32'(hs_a), 32'(ea.hs));
      checkOutput("a_vs", 32'(vs_a), 32'(ea.vs));
      checkOutput("a_blank", 32'(blank_a), 32'(ea.blank));
      checkOutput("a_pix_stb", 32'(stb_a), 32'(ea.stb));
      checkOutput("a_line_start", 32'(ls_a), 32'(ea.ls));
      checkOutput("a_frame_start", 32'(fs_a), 32'(ea.fs));
      checkOutput("b_col", 32'(col_b), 32'(eb.col));
      checkOutput("b_row", 32'(row_b), 32'(eb.row));
      checkOutput("b_hs", 32'(hs_b), 32'(eb.hs));
      checkOutput("b_vs", 32'(vs_b), 32'(eb.vs));
      checkOutput("b_blank", 32'(blank_b), 32'(eb.blank));
      checkOutput("b_pix_stb", 32'(stb_b), 32'(eb.stb));
      checkOutput("b_line_start", 32'(ls_b), 32'(eb.ls));
      checkOutput("b_frame_start", 32'(fs_b), 32'(eb.fs));
`ifdef VGA_FRAME_COUNT_EN
      checkOutput("a_frame_cnt", 32'(fcnt_a), 32'(fc_a));
      checkOutput("b_frame_cnt", 32'(fcnt_b), 32'(fc_b));
`endif
    end
  end

  initial begin
    int t_fa[$];
    int t_fb[$];
    int t_lb[$];
    reset = 1'b1;
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    applyStimulus(1'b1, 1'b0, 2);

    // Clean run from reset: measure frame and line periods directly.
    reset = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (fs_a === 1'b1) t_fa.push_back(i);
      if (fs_b === 1'b1) t_fb.push_back(i);
      if (ls_b === 1'b1) t_lb.push_back(i);
    end
    checkOutput("a_frame_starts_seen", 32'(t_fa.size()), 32'd2);
    if (t_fa.size() >= 2) checkOutput("a_frame_period", 32'(t_fa[1] - t_fa[0]), 32'(2 * A_FRAME));
    if (t_fb.size() >= 2) checkOutput("b_frame_period", 32'(t_fb[1] - t_fb[0]), 32'(B_FRAME));
    else checkOutput("b_frame_starts_seen", 32'(t_fb.size()), 32'd5);
    if (t_lb.size() >= 2) checkOutput("b_line_period", 32'(t_lb[1] - t_lb[0]), 32'd14);
    else checkOutput("b_line_starts_seen", 32'(t_lb.size()), 32'd35);

    applyStimulus(1'b0, 1'b0, 100);
    applyStimulus(1'b0, 1'b1, 37);
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 20);

    for (int s = 0; s < 60; s++) begin
      int mode;
      mode = int'($urandom_range(0, 9));
      if (mode < 6) begin
        applyStimulus(1'b0, 1'b1, int'($urandom_range(1, 150)));
      end else if (mode < 9) begin
        for (int c = 0; c < 40; c++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1);
      end else begin
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1);
      end
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
